// File: rtl/mm_pkg.sv
// Shared types and width helpers for the matrix-vector controller.
package mm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } mm_state_e;

  localparam int PERF_W = 16;

  // Full-precision accumulator: one product plus log2(N) bits of growth.
  function automatic int acc_w(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mm_mac.sv
// Signed multiply-accumulate: single-cycle product added into a full-precision accumulator.
// Clear has priority over enable; accumulator holds when neither is asserted.
module mm_mac #(
  parameter int DW   = 8,
  parameter int AccW = 18
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic [DW-1:0]   i_a,
  input  logic [DW-1:0]   i_b,
  output logic [AccW-1:0] o_acc
);

  logic signed [2*DW-1:0] w_a;
  logic signed [2*DW-1:0] w_b;
  logic signed [2*DW-1:0] w_prod;
  logic        [AccW-1:0] w_prod_ext;
  logic        [AccW-1:0] r_acc;

  // Operands widened first so the low 2*DW product bits are exact.
  assign w_a        = {{DW{i_a[DW-1]}}, i_a};
  assign w_b        = {{DW{i_b[DW-1]}}, i_b};
  assign w_prod     = w_a * w_b;
  assign w_prod_ext = {{(AccW-2*DW){w_prod[2*DW-1]}}, w_prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mm_ctrl.sv
// Matrix-vector controller: streams R rows of A against vector B through one MAC, one result per row.
// Optional cycle counter output cyc_cnt is enabled by defining MM_CTRL_PERF_EN.
module mm_ctrl
  import mm_pkg::*;
#(
  parameter int DW         = 8,
  parameter int N          = 4,
  parameter int R          = 4,
  parameter int BRAM_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          a_rd_en,
  output logic                          b_rd_en,
  output logic [$clog2(BRAM_DEPTH)-1:0] a_addr,
  output logic [$clog2(BRAM_DEPTH)-1:0] b_addr,
  input  logic [DW-1:0]                 a_rd_data,
  input  logic [DW-1:0]                 b_rd_data,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [acc_w(DW, N)-1:0]       res_data,
  output logic [idx_w(R)-1:0]           res_row
`ifdef MM_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]             cyc_cnt
`endif
);

  localparam int AW   = $clog2(BRAM_DEPTH);
  localparam int ACCW = acc_w(DW, N);
  localparam int RW   = idx_w(R);
  localparam int KW   = idx_w(N);

  localparam logic [KW-1:0] K_LAST   = KW'(N - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(R - 1);

  mm_state_e     r_state;
  logic          r_busy;
  logic          r_rd_en;
  logic          r_vld;
  logic          r_res_valid;
  logic [AW-1:0] r_a_addr;
  logic [AW-1:0] r_b_addr;
  logic [KW-1:0] r_k;
  logic [RW-1:0] r_row;

  logic            w_start_acc;
  logic            w_hs;
  logic            w_last_row;
  logic            w_clr;
  logic [ACCW-1:0] w_acc;

  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_hs        = r_res_valid && res_ready;
  assign w_last_row  = (r_row == ROW_LAST);
  // Clear lands on the same edge that enters RUN, so the row starts from zero.
  assign w_clr       = w_start_acc || (w_hs && !w_last_row);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_vld       <= 1'b0;
      r_res_valid <= 1'b0;
      r_a_addr    <= '0;
      r_b_addr    <= '0;
      r_k         <= '0;
      r_row       <= '0;
    end else begin
      r_vld <= r_rd_en;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state  <= ST_RUN;
            r_busy   <= 1'b1;
            r_rd_en  <= 1'b1;
            r_a_addr <= '0;
            r_b_addr <= '0;
            r_k      <= '0;
            r_row    <= '0;
          end
        end
        ST_RUN: begin
          if (r_k == K_LAST) begin
            r_state <= ST_DRAIN;
            r_rd_en <= 1'b0;
          end else begin
            r_k      <= r_k + KW'(1);
            r_a_addr <= r_a_addr + AW'(1);
            r_b_addr <= r_b_addr + AW'(1);
          end
        end
        ST_DRAIN: begin
          r_state     <= ST_OUT;
          r_res_valid <= 1'b1;
        end
        ST_OUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (w_last_row) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              // Rows are contiguous in A, so the next row begins one past the last read.
              r_state  <= ST_RUN;
              r_rd_en  <= 1'b1;
              r_row    <= r_row + RW'(1);
              r_k      <= '0;
              r_a_addr <= r_a_addr + AW'(1);
              r_b_addr <= '0;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_rd_en     <= 1'b0;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  mm_mac #(
    .DW   (DW),
    .AccW (ACCW)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_en  (r_vld),
    .i_a   (a_rd_data),
    .i_b   (b_rd_data),
    .o_acc (w_acc)
  );

`ifdef MM_CTRL_PERF_EN
  logic [PERF_W-1:0] r_cyc_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (start) begin
        r_cyc_cnt <= '0;
      end
    end else if (r_cyc_cnt != {PERF_W{1'b1}}) begin
      r_cyc_cnt <= r_cyc_cnt + PERF_W'(1);
    end
  end

  assign cyc_cnt = r_cyc_cnt;
`endif

  assign busy      = r_busy;
  assign a_rd_en   = r_rd_en;
  assign b_rd_en   = r_rd_en;
  assign a_addr    = r_a_addr;
  assign b_addr    = r_b_addr;
  assign res_valid = r_res_valid;
  assign res_data  = w_acc;
  assign res_row   = r_row;
  // Completion must coincide with the final handshake, so it follows res_ready directly.
  assign done      = w_hs && w_last_row;

endmodule

// File: tb/tb_mm_ctrl.sv
// Testbench for mm_ctrl: BRAM models plus a dot-product reference computed from the memory contents.
module tb_mm_ctrl;
  import mm_pkg::*;

  localparam int DW         = 8;
  localparam int N          = 4;
  localparam int R          = 4;
  localparam int BRAM_DEPTH = 16;
  localparam int AW         = $clog2(BRAM_DEPTH);
  localparam int ACCW       = acc_w(DW, N);
  localparam int RW         = idx_w(R);
  localparam int JOB_CYC    = R * (N + 2);

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b0;
  logic            start     = 1'b0;
  logic            res_ready = 1'b0;
  logic            busy, done, a_rd_en, b_rd_en, res_valid;
  logic [AW-1:0]   a_addr, b_addr;
  logic [DW-1:0]   a_rd_data = '0;
  logic [DW-1:0]   b_rd_data = '0;
  logic [ACCW-1:0] res_data;
  logic [RW-1:0]   res_row;
`ifdef MM_CTRL_PERF_EN
  logic [15:0]     cyc_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic signed [DW-1:0] mem_a [BRAM_DEPTH];
  logic signed [DW-1:0] mem_b [BRAM_DEPTH];

  logic [ACCW-1:0] obs_dat [$];
  int              obs_row [$];
  int              done_cyc[$];
  int              first_rd, first_vld, hold_err, stall_cnt, timeout;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= mem_a[a_addr];
    if (b_rd_en) b_rd_data <= mem_b[b_addr];
  end

  mm_ctrl #(
    .DW(DW), .N(N), .R(R), .BRAM_DEPTH(BRAM_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .a_rd_en   (a_rd_en),
    .b_rd_en   (b_rd_en),
    .a_addr    (a_addr),
    .b_addr    (b_addr),
    .a_rd_data (a_rd_data),
    .b_rd_data (b_rd_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_row   (res_row)
`ifdef MM_CTRL_PERF_EN
    ,
    .cyc_cnt   (cyc_cnt)
`endif
  );

  // Dot product of row r of A with B, straight from the memory images.
  function automatic logic [ACCW-1:0] model_row(input int r);
    int s = 0;
    logic [31:0] t;
    for (int k = 0; k < N; k++) s += int'(mem_a[r*N+k]) * int'(mem_b[k]);
    t = s;
    return t[ACCW-1:0];
  endfunction

  task automatic load_random();
    for (int i = 0; i < BRAM_DEPTH; i++) begin
      mem_a[i] = DW'($urandom);
      mem_b[i] = DW'($urandom);
    end
  endtask

  // ready_mode: 0 always ready, 1 hold off stall_row for 5 cycles, 2 random.
  task automatic run_job(input int ready_mode, input int stall_row, input int njobs,
                         input bit hold_start, input bit junk_start);
    int cyc = 0;
    int seen = 0;
    bit in_stall = 0;
    bit r;
    logic [ACCW-1:0] held_d = '0;
    logic [RW-1:0]   held_r = '0;
    obs_dat.delete(); obs_row.delete(); done_cyc.delete();
    first_rd = -1; first_vld = -1; hold_err = 0; stall_cnt = 0; timeout = 0;
    @(negedge clk);
    start = 1'b1;
    while (seen < njobs && timeout == 0) begin
      @(negedge clk);
      cyc++;
      if (!hold_start) start = junk_start ? 1'($urandom_range(0, 1)) : 1'b0;
      case (ready_mode)
        1:       r = !(res_valid && res_row == RW'(stall_row) && stall_cnt < 5);
        2:       r = 1'($urandom_range(0, 1));
        default: r = 1'b1;
      endcase
      res_ready = r;
      #1;
      if (a_rd_en && first_rd < 0) first_rd = cyc;
      if (res_valid && first_vld < 0) first_vld = cyc;
      if (res_valid && !res_ready) begin
        if (in_stall && (res_data !== held_d || res_row !== held_r)) hold_err++;
        if (a_rd_en || b_rd_en) hold_err++;
        held_d = res_data; held_r = res_row; in_stall = 1; stall_cnt++;
      end else begin
        in_stall = 0;
      end
      if (res_valid && res_ready) begin
        obs_dat.push_back(res_data);
        obs_row.push_back(int'(res_row));
      end
      if (done) begin
        done_cyc.push_back(cyc);
        seen++;
      end
      if (cyc > 400) timeout = 1;
    end
    start = 1'b0;
    res_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, a_rd_en, b_rd_en, res_valid, done} !== 5'b0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: busy/rda/rdb/vld/done=%b required 00000", i,
                 {busy, a_rd_en, b_rd_en, res_valid, done});
      end
    end
    checks++;
    if (a_addr !== '0 || b_addr !== '0 || res_data !== '0 || res_row !== '0) begin
      errors++;
      $display("FAIL reset_values a=%0d b=%0d data=%0d row=%0d required all 0",
               a_addr, b_addr, res_data, res_row);
    end
`ifdef MM_CTRL_PERF_EN
    checks++;
    if (cyc_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cyc_cnt got %0d required 0", cyc_cnt);
    end
`endif
  endtask

  task automatic test_identity();
    for (int i = 0; i < BRAM_DEPTH; i++) begin
      mem_a[i] = ((i / N) == (i % N) && i < R*N) ? 8'sd1 : 8'sd0;
      mem_b[i] = (i < N) ? DW'(i + 1) : '0;
    end
    run_job(0, 0, 1, 1'b0, 1'b0);
    checks++;
    if (timeout != 0 || obs_dat.size() != R) begin
      errors++;
      $display("FAIL ident_count got %0d results timeout=%0d required %0d", obs_dat.size(), timeout, R);
    end
    for (int i = 0; i < R && i < obs_dat.size(); i++) begin
      checks++;
      if (obs_dat[i] !== ACCW'(i + 1) || obs_row[i] != i) begin
        errors++;
        $display("FAIL ident_row%0d got data=%0d row=%0d required data=%0d row=%0d",
                 i, obs_dat[i], obs_row[i], i + 1, i);
      end
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != JOB_CYC) begin
      errors++;
      $display("FAIL ident_done_cycle got %0d required %0d",
               (done_cyc.size() > 0) ? done_cyc[0] : -1, JOB_CYC);
    end
    checks++;
    if (first_rd != 1) begin
      errors++;
      $display("FAIL first_read_latency got %0d required 1", first_rd);
    end
    checks++;
    if (first_vld - first_rd != N + 1) begin
      errors++;
      $display("FAIL res_valid_latency got %0d required %0d", first_vld - first_rd, N + 1);
    end
`ifdef MM_CTRL_PERF_EN
    @(negedge clk);
    checks++;
    if (cyc_cnt !== 16'(JOB_CYC)) begin
      errors++;
      $display("FAIL ident_cyc_cnt got %0d required %0d", cyc_cnt, JOB_CYC);
    end
`endif
  endtask

  task automatic test_min_values();
    for (int i = 0; i < BRAM_DEPTH; i++) begin
      mem_a[i] = -8'sd128;
      mem_b[i] = -8'sd128;
    end
    run_job(0, 0, 1, 1'b0, 1'b0);
    checks++;
    if (obs_dat.size() != R) begin
      errors++;
      $display("FAIL min_count got %0d required %0d", obs_dat.size(), R);
    end
    for (int i = 0; i < obs_dat.size(); i++) begin
      checks++;
      if (obs_dat[i] !== ACCW'(65536)) begin
        errors++;
        $display("FAIL min_row%0d got %0d required 65536", i, obs_dat[i]);
      end
    end
  endtask

  task automatic test_stall();
    load_random();
    run_job(1, 1, 1, 1'b0, 1'b0);
    checks++;
    if (obs_dat.size() != R || stall_cnt != 5) begin
      errors++;
      $display("FAIL stall_count got %0d results %0d stalls required %0d and 5",
               obs_dat.size(), stall_cnt, R);
    end
    for (int i = 0; i < obs_dat.size(); i++) begin
      checks++;
      if (obs_dat[i] !== model_row(i) || obs_row[i] != i) begin
        errors++;
        $display("FAIL stall_row%0d got %0d/%0d required %0d/%0d",
                 i, obs_dat[i], obs_row[i], model_row(i), i);
      end
    end
    checks++;
    if (hold_err != 0) begin
      errors++;
      $display("FAIL stall_hold got %0d violations required 0", hold_err);
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != JOB_CYC + 5) begin
      errors++;
      $display("FAIL stall_done_cycle got %0d required %0d",
               (done_cyc.size() > 0) ? done_cyc[0] : -1, JOB_CYC + 5);
    end
`ifdef MM_CTRL_PERF_EN
    @(negedge clk);
    checks++;
    if (cyc_cnt !== 16'(JOB_CYC + 5)) begin
      errors++;
      $display("FAIL stall_cyc_cnt got %0d required %0d", cyc_cnt, JOB_CYC + 5);
    end
`endif
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      load_random();
      run_job(2, 0, 1, 1'b0, 1'b0);
      checks++;
      if (obs_dat.size() != R || done_cyc.size() != 1) begin
        errors++;
        $display("FAIL rand%0d_count got %0d results %0d dones required %0d and 1",
                 it, obs_dat.size(), done_cyc.size(), R);
      end
      for (int i = 0; i < obs_dat.size(); i++) begin
        checks++;
        if (obs_dat[i] !== model_row(i) || obs_row[i] != i) begin
          errors++;
          $display("FAIL rand%0d_row%0d got %0d/%0d required %0d/%0d",
                   it, i, obs_dat[i], obs_row[i], model_row(i), i);
        end
      end
    end
  endtask

  task automatic test_busy_start();
    load_random();
    run_job(0, 0, 1, 1'b0, 1'b1);
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != JOB_CYC || obs_dat.size() != R) begin
      errors++;
      $display("FAIL busy_start got done=%0d results=%0d required done=%0d results=%0d",
               (done_cyc.size() > 0) ? done_cyc[0] : -1, obs_dat.size(), JOB_CYC, R);
    end
    for (int i = 0; i < obs_dat.size(); i++) begin
      checks++;
      if (obs_dat[i] !== model_row(i)) begin
        errors++;
        $display("FAIL busy_start_row%0d got %0d required %0d", i, obs_dat[i], model_row(i));
      end
    end
`ifdef MM_CTRL_PERF_EN
    @(negedge clk);
    checks++;
    if (cyc_cnt !== 16'(JOB_CYC)) begin
      errors++;
      $display("FAIL busy_start_cyc_cnt got %0d required %0d", cyc_cnt, JOB_CYC);
    end
`endif
  endtask

  task automatic test_back_to_back();
    load_random();
    run_job(0, 0, 2, 1'b1, 1'b0);
    checks++;
    if (done_cyc.size() != 2 || done_cyc[0] != JOB_CYC || done_cyc[1] != 2*JOB_CYC + 1) begin
      errors++;
      $display("FAIL b2b_done got %0d dones first=%0d second=%0d required %0d and %0d",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1,
               (done_cyc.size() > 1) ? done_cyc[1] : -1, JOB_CYC, 2*JOB_CYC + 1);
    end
    checks++;
    if (obs_dat.size() != 2*R) begin
      errors++;
      $display("FAIL b2b_count got %0d required %0d", obs_dat.size(), 2*R);
    end
    for (int i = 0; i < obs_dat.size(); i++) begin
      checks++;
      if (obs_dat[i] !== model_row(i % R) || obs_row[i] != i % R) begin
        errors++;
        $display("FAIL b2b_res%0d got %0d/%0d required %0d/%0d",
                 i, obs_dat[i], obs_row[i], model_row(i % R), i % R);
      end
    end
  endtask

  task automatic test_reset_midjob();
    int n = 0;
    int bad = 0;
    load_random();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!(a_rd_en && a_addr >= AW'(2*N)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL midjob_reach_row2 got no row 2 read within 100 cycles required one");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, a_rd_en, b_rd_en, res_valid} !== 5'b0 || a_addr !== '0 ||
        b_addr !== '0 || res_data !== '0 || res_row !== '0) begin
      errors++;
      $display("FAIL midjob_async_reset got busy=%b done=%b rd=%b%b vld=%b a=%0d b=%0d data=%0d row=%0d required all 0",
               busy, done, a_rd_en, b_rd_en, res_valid, a_addr, b_addr, res_data, res_row);
    end
`ifdef MM_CTRL_PERF_EN
    checks++;
    if (cyc_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midjob_cyc_cnt got %0d required 0", cyc_cnt);
    end
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid || done || busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midjob_abandoned got %0d active cycles required 0", bad);
    end
    run_job(0, 0, 1, 1'b0, 1'b0);
    checks++;
    if (obs_dat.size() != R || done_cyc.size() != 1) begin
      errors++;
      $display("FAIL midjob_restart_count got %0d results required %0d", obs_dat.size(), R);
    end
    for (int i = 0; i < obs_dat.size(); i++) begin
      checks++;
      if (obs_dat[i] !== model_row(i) || obs_row[i] != i) begin
        errors++;
        $display("FAIL midjob_row%0d got %0d/%0d required %0d/%0d",
                 i, obs_dat[i], obs_row[i], model_row(i), i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_min_values();
    test_stall();
    test_random();
    test_busy_start();
    test_back_to_back();
    test_reset_midjob();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached required completion");
    $fatal(1, "watchdog");
  end

endmodule
